matrix_matrix_10x10_pipelined: RTL and testbench
================================================

// Module: matrix_matrix_10x10_pipelined
// PURPOSE
//   Pipelined 10x10 by 10x10 unsigned matrix multiplier, C = A x B.
//   Both matrices arrive as flat buses and the product leaves as a flat bus.
//   Fully parallel: 1000 multipliers. Accepts one new matrix pair every clock
//   and has a fixed latency. Top-level compute block; no handshake.
// PARAMETERS
//   N   10  matrix dimension (rows = cols = N); design verified at 10 only
//   DW  8   element width of A and B (unsigned)
//   OW  16  element width of result (unsigned, modulo 2^OW)
// PORTS
//   clk       in   1          rising-edge clock
//   reset     in   1          asynchronous, active-high reset
//   matrix_a  in   N*N*DW=800 A[i][j] = matrix_a[i*80 + j*8 +: 8]
//   matrix_b  in   N*N*DW=800 B[i][j] = matrix_b[i*80 + j*8 +: 8]
//   result    out  N*N*OW=1600 C[i][j] = result[i*160 + j*16 +: 16]
// BEHAVIOUR
//   - Math: C[i][j] = sum over k=0..9 of A[i][k]*B[k][j].
//     All operands unsigned. Each product is an exact 16-bit value.
//     Sums wrap modulo 2^16, with no saturation and no overflow flag.
//   - Pipeline has 4 register stages, all on rising clk:
//     S1: register matrix_a and matrix_b.
//     S2: register all 1000 products p[i][j][k] (16 b).
//     S3: register two partial sums per output element:
//         k=0..4 and k=5..9 (16 b, wrapping).
//     S4: register the final sum of the two partials into result.
//   - Latency: inputs sampled at rising edge E appear on result just after
//     edge E+3, i.e. 4 edges including the sampling edge.
//     result is a registered output with no combinational path from inputs.
//   - Throughput: one matrix pair per cycle.
//     Back-to-back different inputs produce back-to-back results in order,
//     with no bubbles.
//   - Inputs are treated as level data, with no valid signal.
//     A steady input gives a steady result from latency onward.
//   - Reset clears every pipeline register and result to all zeros
//     immediately, independent of clk.
//   - Reset asserted mid-operation discards in-flight data.
//     result stays 0 while reset is high.
//   - After reset deasserts, result reflects the inputs sampled on the
//     first edge after release, 4 edges later.
//     Before that, result shows zeros propagating, which equals A=B=0.
//   - No X-propagation: every register has a defined reset value.
// TESTING
//   1. Reset: hold reset with random inputs, toggle clk 5 times
//      -> result == 0 throughout. Asserting reset between edges clears
//      result without a clock edge.
//   2. Row/column pattern: A row i all (i+1), B column j all (j+1), release
//      reset -> C[i][j]=10(i+1)(j+1). Checks: C[0][0]=10, C[2][4]=150,
//      C[9][0]=100, C[9][9]=1000. Valid after 4 edges, stable thereafter.
//   3. Identity: A=I, B random bytes -> C[i][j] equals B[i][j]
//      zero-extended to 16 b. Then swap so B=I: C equals A.
//   4. Overflow: all elements 255 -> every C[i][j] = 650250 mod 65536 = 60426.
//      Mixed case: A[0][*]=255, B[*][0]=1 -> C[0][0]=2550.
//   5. Streaming: new random pair each cycle for 50 cycles -> result at
//      cycle t+4 equals the reference model of the pair applied at cycle t,
//      for every t, with no gaps.
//   6. Reset mid-stream: assert reset during streaming of case 5
//      -> result = 0 at once. After release, the first non-zero-model output
//      comes exactly 4 edges after the first post-release sample.

Source files
------------

// File: rtl/matrix_matrix_10x10_pipelined.sv
// Pipelined N x N unsigned matrix multiplier, C = A x B.
// Four register stages: input capture, products, two half-row partial sums,
// final sum. One new matrix pair is accepted every clock and sums wrap
// modulo 2^OW.
module matrix_matrix_10x10_pipelined #(
  parameter int N  = 10,
  parameter int DW = 8,
  parameter int OW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N*N*DW-1:0] matrix_a,
  input  logic [N*N*DW-1:0] matrix_b,
  output logic [N*N*OW-1:0] result
);

  // Split point of the inner product into two partial sums.
  localparam int H = N / 2;

  // Full-precision product, kept to the low OW bits.
  function automatic logic [OW-1:0] mul_wrap(input logic [DW-1:0] x,
                                             input logic [DW-1:0] y);
    logic [2*DW-1:0] full;
    full = {{DW{1'b0}}, x} * {{DW{1'b0}}, y};
    return OW'(full);
  endfunction

  // Modulo-2^OW addition; the carry out is dropped on purpose.
  function automatic logic [OW-1:0] add_wrap(input logic [OW-1:0] x,
                                             input logic [OW-1:0] y);
    return x + y;
  endfunction

  logic [N*N*DW-1:0] a_p0;
  logic [N*N*DW-1:0] b_p0;
  logic [OW-1:0]     prod_p1    [N][N][N];
  logic [OW-1:0]     psum_lo_c  [N][N];
  logic [OW-1:0]     psum_hi_c  [N][N];
  logic [OW-1:0]     psum_lo_p2 [N][N];
  logic [OW-1:0]     psum_hi_p2 [N][N];

  // ---- Stage p0: capture both operand matrices ----
  // Register the raw input buses; this isolates result from the inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_p0 <= '0;
      b_p0 <= '0;
    end else begin
      a_p0 <= matrix_a;
      b_p0 <= matrix_b;
    end
  end

  // ---- Stage p1: all N^3 element products ----
  // prod_p1[i][j][k] = A[i][k] * B[k][j].
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          for (int k = 0; k < N; k++)
            prod_p1[i][j][k] <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          for (int k = 0; k < N; k++)
            prod_p1[i][j][k] <= mul_wrap(a_p0[(i*N+k)*DW +: DW],
                                         b_p0[(k*N+j)*DW +: DW]);
    end
  end

  // Adder trees for the lower (k < H) and upper (k >= H) halves of each dot product.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        psum_lo_c[i][j] = '0;
        psum_hi_c[i][j] = '0;
        for (int k = 0; k < H; k++)
          psum_lo_c[i][j] = add_wrap(psum_lo_c[i][j], prod_p1[i][j][k]);
        for (int k = H; k < N; k++)
          psum_hi_c[i][j] = add_wrap(psum_hi_c[i][j], prod_p1[i][j][k]);
      end
    end
  end

  // ---- Stage p2: two partial sums per output element ----
  // Register the half-sums so each stage has a short adder chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          psum_lo_p2[i][j] <= '0;
          psum_hi_p2[i][j] <= '0;
        end
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          psum_lo_p2[i][j] <= psum_lo_c[i][j];
          psum_hi_p2[i][j] <= psum_hi_c[i][j];
        end
    end
  end

  // ---- Stage p3: final sum into the output register ----
  // Combine the two partials and pack C[i][j] onto the result bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          result[(i*N+j)*OW +: OW] <= add_wrap(psum_lo_p2[i][j], psum_hi_p2[i][j]);
    end
  end

endmodule

// File: tb/tb_matrix_matrix_10x10_pipelined.sv
// Bench for matrix_matrix_10x10_pipelined: randomized and directed matrix
// pairs checked every cycle against a behavioural matrix-product model.
module tb_matrix_matrix_10x10_pipelined;

  logic           clk;
  logic           reset;
  logic [799:0]   matrix_a;
  logic [799:0]   matrix_b;
  logic [1599:0]  result;

  int errors = 0;
  int checks = 0;

  logic [1599:0] zero_v = '0;
  logic [1599:0] exp_pipe [4];
  logic [1599:0] ex1;

  matrix_matrix_10x10_pipelined dut (
    .clk      (clk),
    .reset    (reset),
    .matrix_a (matrix_a),
    .matrix_b (matrix_b),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product: plain integer dot products reduced mod 65536.
  function automatic logic [1599:0] ref_mul(input logic [799:0] a, input logic [799:0] b);
    logic [1599:0] r;
    int unsigned acc;
    int unsigned av;
    int unsigned bv;
    r = '0;
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 10; j++) begin
        acc = 0;
        for (int k = 0; k < 10; k++) begin
          av = int'(a[i*80 + k*8 +: 8]);
          bv = int'(b[k*80 + j*8 +: 8]);
          acc = acc + av * bv;
        end
        r[i*160 + j*16 +: 16] = 16'(acc % 65536);
      end
    return r;
  endfunction

  function automatic logic [799:0] rnd800();
    logic [799:0] v;
    for (int w = 0; w < 25; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [799:0] ident();
    logic [799:0] v;
    v = '0;
    for (int i = 0; i < 10; i++) v[i*80 + i*8 +: 8] = 8'd1;
    return v;
  endfunction

  function automatic logic [15:0] c_el(input logic [1599:0] v, input int i, input int j);
    return v[i*160 + j*16 +: 16];
  endfunction

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input string name, input logic [1599:0] act, input logic [1599:0] exp);
    int bad;
    bad = -1;
    checks++;
    for (int e = 99; e >= 0; e--)
      if (act[e*16 +: 16] !== exp[e*16 +: 16]) bad = e;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s C[%0d][%0d] actual=%0d required=%0d at %0t", name, bad / 10, bad % 10,
               act[bad*16 +: 16], exp[bad*16 +: 16], $time);
    end
  endtask

  // Model: the product of the pair sampled on an edge is due three edges later.
  always @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < 4; s++) exp_pipe[s] = '0;
    end else begin
      for (int s = 0; s < 3; s++) exp_pipe[s] = exp_pipe[s+1];
      exp_pipe[3] = ref_mul(matrix_a, matrix_b);
    end
    #2;
    chk_vec("pipeline", result, reset ? zero_v : exp_pipe[0]);
  end

  initial begin
    logic [799:0] a;
    logic [799:0] b;

    // 1. Reset held with random inputs.
    reset = 1'b1;
    matrix_a = rnd800();
    matrix_b = rnd800();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk_vec("reset_hold", result, zero_v);
      matrix_a = rnd800();
      matrix_b = rnd800();
    end

    // 2. Row/column pattern released out of reset.
    @(negedge clk);
    a = '0;
    b = '0;
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 10; j++) begin
        a[i*80 + j*8 +: 8] = 8'(i + 1);
        b[i*80 + j*8 +: 8] = 8'(j + 1);
      end
    matrix_a = a;
    matrix_b = b;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk16("rowcol_00", c_el(result, 0, 0), 16'd10);
    chk16("rowcol_24", c_el(result, 2, 4), 16'd150);
    chk16("rowcol_90", c_el(result, 9, 0), 16'd100);
    chk16("rowcol_99", c_el(result, 9, 9), 16'd1000);
    @(negedge clk);
    chk16("rowcol_99_stable", c_el(result, 9, 9), 16'd1000);

    // Reset between edges clears result with no clock edge.
    #2;
    reset = 1'b1;
    #1;
    chk_vec("async_reset", result, zero_v);
    @(negedge clk);
    reset = 1'b0;

    // 3. Identity on each side.
    b = rnd800();
    matrix_a = ident();
    matrix_b = b;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 10; j++)
        chk16("ident_left", c_el(result, i, j), {8'd0, b[i*80 + j*8 +: 8]});
    a = rnd800();
    matrix_a = a;
    matrix_b = ident();
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 10; j++)
        chk16("ident_right", c_el(result, i, j), {8'd0, a[i*80 + j*8 +: 8]});

    // 4. Overflow and mixed case.
    matrix_a = '1;
    matrix_b = '1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 10; j++)
        chk16("overflow", c_el(result, i, j), 16'd60426);
    a = '0;
    b = '0;
    for (int k = 0; k < 10; k++) begin
      a[k*8 +: 8] = 8'd255;
      b[k*80 +: 8] = 8'd1;
    end
    matrix_a = a;
    matrix_b = b;
    repeat (4) @(negedge clk);
    chk16("mixed_00", c_el(result, 0, 0), 16'd2550);

    // 5. Streaming random pairs, one per cycle.
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      matrix_a = rnd800();
      matrix_b = rnd800();
    end
    repeat (4) @(negedge clk);

    // 6. Reset in the middle of a stream.
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      matrix_a = rnd800();
      matrix_b = rnd800();
    end
    #2;
    reset = 1'b1;
    #1;
    chk_vec("midstream_reset", result, zero_v);
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      matrix_a = rnd800();
      matrix_b = rnd800();
    end
    @(negedge clk);
    reset = 1'b0;
    matrix_a = rnd800();
    matrix_b = rnd800();
    ex1 = ref_mul(matrix_a, matrix_b);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 3) chk_vec("post_release_zero", result, zero_v);
      if (n == 4) chk_vec("post_release_first", result, ex1);
      matrix_a = rnd800();
      matrix_b = rnd800();
    end
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      matrix_a = rnd800();
      matrix_b = rnd800();
    end
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
